uart_harness_adapter: RTL and testbench

- Harness-side serial endpoint wired directly to the UART sink domain's serial pins: consumes its txd, drives its rxd.
- Decodes 8N1 frames from the DUT into a byte FIFO for the simulation host.
- Serializes host bytes into frames on the DUT's rxd.
- Single clock domain, clocked from the same clock that feeds the UART sink domain.

---
 rtl/uart_harness_adapter_if.sv | 25 ++
 rtl/uart_harness_adapter.sv | 161 ++++++++++++++++
 tb/tb_uart_harness_adapter.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_harness_adapter_if.sv
// uart_harness_adapter_if: serial pins, host byte streams and status flags of the harness UART adapter.
interface uart_harness_adapter_if #(
    parameter int DATA_BITS = 8
);
    logic                 uart_txd;
    logic                 uart_rxd;
    logic                 rx_valid;
    logic                 rx_ready;
    logic [DATA_BITS-1:0] rx_bits;
    logic                 tx_valid;
    logic                 tx_ready;
    logic [DATA_BITS-1:0] tx_bits;
    logic                 rx_overflow;
    logic                 rx_frame_err;

    modport slave (
        input  uart_txd, rx_ready, tx_valid, tx_bits,
        output uart_rxd, rx_valid, rx_bits, tx_ready, rx_overflow, rx_frame_err
    );

    modport master (
        output uart_txd, rx_ready, tx_valid, tx_bits,
        input  uart_rxd, rx_valid, rx_bits, tx_ready, rx_overflow, rx_frame_err
    );
endinterface

// File: rtl/uart_harness_adapter.sv
// uart_harness_adapter: harness-side 8N1 endpoint; decodes DUT txd frames into a FIFO and serializes host bytes onto DUT rxd.
module uart_harness_adapter #(
    parameter int DIV        = 16,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 8
) (
    input logic clock,
    input logic reset,
    uart_harness_adapter_if.slave bus
);
    localparam int CW = $clog2(DIV);
    localparam int IW = $clog2(DATA_BITS + 1);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = DATA_BITS + STOP_BITS;
    localparam int NW = $clog2(TW + 1);

    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
    typedef enum logic {T_IDLE, T_BUSY} tx_state_t;

    logic                 s1, s;
    rx_state_t            rstate;
    logic                 armed;
    logic [CW-1:0]        rcnt;
    logic [IW-1:0]        ridx;
    logic [DATA_BITS-1:0] rsh;
    logic                 frame_err;

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wp, rp;
    logic [AW:0]          count;
    logic                 push, pop, full, wr, overflow;

    tx_state_t            tstate;
    logic [CW-1:0]        tcnt;
    logic [NW-1:0]        tleft;
    logic [TW-1:0]        tsh;
    logic                 rxd, tready;

    assign push = rstate == R_STOP && rcnt == '0 && s;
    assign full = count == (AW+1)'(FIFO_DEPTH);
    assign pop  = count != '0 && bus.rx_ready;
    assign wr   = push && (!full || pop);

    always_ff @(posedge clock) begin
        if (!reset) {s1, s} <= 2'b11;
        else        {s1, s} <= {bus.uart_txd, s1};
    end

    // Unarmed after reset or a bad stop bit, so a held-low line reports one error only.
    always_ff @(posedge clock) begin
        if (!reset) begin
            rstate    <= R_IDLE;
            armed     <= 1'b0;
            rcnt      <= '0;
            ridx      <= '0;
            rsh       <= '0;
            frame_err <= 1'b0;
        end else begin
            case (rstate)
                R_IDLE: begin
                    armed <= armed | s;
                    if (armed && !s) begin
                        rcnt   <= CW'(DIV / 2 - 1);
                        rstate <= R_START;
                    end
                end
                R_START: begin
                    if (rcnt != '0) rcnt <= rcnt - 1'b1;
                    else if (!s) begin
                        rcnt   <= CW'(DIV - 1);
                        ridx   <= '0;
                        rstate <= R_DATA;
                    end else rstate <= R_IDLE;
                end
                R_DATA: begin
                    if (rcnt != '0) rcnt <= rcnt - 1'b1;
                    else begin
                        rsh  <= {s, rsh[DATA_BITS-1:1]};
                        rcnt <= CW'(DIV - 1);
                        ridx <= ridx + 1'b1;
                        if (ridx == IW'(DATA_BITS - 1)) rstate <= R_STOP;
                    end
                end
                R_STOP: begin
                    if (rcnt != '0) rcnt <= rcnt - 1'b1;
                    else begin
                        armed     <= s;
                        frame_err <= frame_err | !s;
                        rstate    <= R_IDLE;
                    end
                end
                default: rstate <= R_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            wp       <= '0;
            rp       <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr) wp <= wp + 1'b1;
            if (pop) rp <= rp + 1'b1;
            count <= count + (AW+1)'(wr) - (AW+1)'(pop);
            if (push && full && !pop) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (wr) mem[wp] <= rsh;
    end

    // The start bit is driven directly on accept; tsh then holds data followed by stop ones.
    always_ff @(posedge clock) begin
        if (!reset) begin
            tstate <= T_IDLE;
            tready <= 1'b0;
            rxd    <= 1'b1;
            tcnt   <= '0;
            tleft  <= '0;
            tsh    <= '0;
        end else begin
            case (tstate)
                T_IDLE: begin
                    if (bus.tx_valid && tready) begin
                        tsh    <= {{STOP_BITS{1'b1}}, bus.tx_bits};
                        tleft  <= NW'(TW);
                        tcnt   <= CW'(DIV - 1);
                        rxd    <= 1'b0;
                        tready <= 1'b0;
                        tstate <= T_BUSY;
                    end else tready <= 1'b1;
                end
                T_BUSY: begin
                    if (tcnt != '0) tcnt <= tcnt - 1'b1;
                    else if (tleft == '0) begin
                        rxd    <= 1'b1;
                        tready <= 1'b1;
                        tstate <= T_IDLE;
                    end else begin
                        rxd   <= tsh[0];
                        tsh   <= tsh >> 1;
                        tleft <= tleft - 1'b1;
                        tcnt  <= CW'(DIV - 1);
                    end
                end
                default: tstate <= T_IDLE;
            endcase
        end
    end

    assign bus.uart_rxd     = rxd;
    assign bus.rx_valid     = count != '0;
    assign bus.rx_bits      = mem[rp];
    assign bus.tx_ready     = tready;
    assign bus.rx_overflow  = overflow;
    assign bus.rx_frame_err = frame_err;
endmodule

// File: tb/tb_uart_harness_adapter.sv
// tb_uart_harness_adapter: directed vectors for the harness UART adapter at DIV=16, 8N1, 8-entry FIFO.
module tb_uart_harness_adapter;
    localparam int DIV = 16;

    logic clock = 1'b0;
    logic reset;
    int   vectors = 0;
    int   miscompares = 0;
    logic [7:0] popped [$];

    uart_harness_adapter_if #(.DATA_BITS(8)) bus ();

    uart_harness_adapter #(
        .DIV(DIV), .DATA_BITS(8), .STOP_BITS(1), .FIFO_DEPTH(8)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (reset && bus.rx_valid && bus.rx_ready) popped.push_back(bus.rx_bits);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Leaves the line at the stop-bit value once the frame is over.
    task automatic rx_frame(input logic [7:0] b, input logic stop);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            bus.uart_txd = f[i];
            tick(DIV);
        end
    endtask

    task automatic tx_send_check(input logic [7:0] b, input string tag);
        logic exp;
        check({tag, "_ready_before"}, 32'(bus.tx_ready), 32'd1);
        bus.tx_valid = 1'b1;
        bus.tx_bits  = b;
        @(posedge clock);
        #1;
        bus.tx_valid = 1'b0;
        bus.tx_bits  = ~b;
        for (int k = 1; k <= 161; k++) begin
            @(negedge clock);
            exp = k <= 16 ? 1'b0 : k <= 144 ? b[(k - 17) / 16] : 1'b1;
            check($sformatf("%s_rxd_c%0d", tag, k), 32'(bus.uart_rxd), 32'(exp));
            if (k >= 160) check($sformatf("%s_ready_c%0d", tag, k), 32'(bus.tx_ready), 32'(k == 161));
        end
    endtask

    initial begin
        reset        = 1'b0;
        bus.uart_txd = 1'b1;
        bus.rx_ready = 1'b0;
        bus.tx_valid = 1'b0;
        bus.tx_bits  = '0;
        tick(3);
        @(negedge clock);
        check("rst_rxd", 32'(bus.uart_rxd), 32'd1);
        check("rst_rx_valid", 32'(bus.rx_valid), 32'd0);
        check("rst_tx_ready", 32'(bus.tx_ready), 32'd0);
        check("rst_overflow", 32'(bus.rx_overflow), 32'd0);
        check("rst_frame_err", 32'(bus.rx_frame_err), 32'd0);
        tick(1);
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check("release_tx_ready", 32'(bus.tx_ready), 32'd1);
        tick(20);

        bus.rx_ready = 1'b1;
        popped.delete();
        rx_frame(8'hA5, 1'b1);
        tick(20);
        check("a5_count", 32'(popped.size()), 32'd1);
        check("a5_value", 32'(popped[0]), 32'hA5);
        check("a5_overflow", 32'(bus.rx_overflow), 32'd0);
        check("a5_frame_err", 32'(bus.rx_frame_err), 32'd0);
        check("a5_valid_after", 32'(bus.rx_valid), 32'd0);

        tick(1);
        tx_send_check(8'h3C, "tx3c");
        tick(5);

        bus.rx_ready = 1'b0;
        popped.delete();
        check("fill_overflow_before", 32'(bus.rx_overflow), 32'd0);
        for (int i = 0; i < 9; i++) rx_frame(8'(i), 1'b1);
        tick(20);
        check("fill_overflow", 32'(bus.rx_overflow), 32'd1);
        check("fill_frame_err", 32'(bus.rx_frame_err), 32'd0);
        check("fill_valid", 32'(bus.rx_valid), 32'd1);
        check("fill_head", 32'(bus.rx_bits), 32'h00);
        tick(5);
        check("fill_head_stable", 32'(bus.rx_bits), 32'h00);
        bus.rx_ready = 1'b1;
        tick(20);
        bus.rx_ready = 1'b0;
        check("drain_count", 32'(popped.size()), 32'd8);
        for (int i = 0; i < 8; i++) check($sformatf("drain_%0d", i), 32'(popped[i]), 32'(i));
        check("drain_valid", 32'(bus.rx_valid), 32'd0);

        bus.rx_ready = 1'b1;
        popped.delete();
        bus.uart_txd = 1'b0;
        tick(4);
        bus.uart_txd = 1'b1;
        tick(40);
        check("glitch_count", 32'(popped.size()), 32'd0);
        check("glitch_frame_err", 32'(bus.rx_frame_err), 32'd0);
        rx_frame(8'h55, 1'b0);
        tick(100);
        check("break_frame_err", 32'(bus.rx_frame_err), 32'd1);
        check("break_count", 32'(popped.size()), 32'd0);
        bus.uart_txd = 1'b1;
        tick(40);
        check("break_end_count", 32'(popped.size()), 32'd0);
        check("break_end_valid", 32'(bus.rx_valid), 32'd0);
        check("overflow_sticky", 32'(bus.rx_overflow), 32'd1);

        bus.rx_ready = 1'b0;
        popped.delete();
        rx_frame(8'h42, 1'b1);
        tick(20);
        check("pre_reset_valid", 32'(bus.rx_valid), 32'd1);
        bus.tx_valid = 1'b1;
        bus.tx_bits  = 8'h00;
        bus.uart_txd = 1'b0;
        tick(1);
        bus.tx_valid = 1'b0;
        tick(15);
        bus.uart_txd = 1'b1;
        tick(56);
        @(negedge clock);
        check("mid_tx_rxd", 32'(bus.uart_rxd), 32'd0);
        check("mid_tx_ready", 32'(bus.tx_ready), 32'd0);
        tick(1);
        reset = 1'b0;
        @(posedge clock);
        @(negedge clock);
        check("mid_rst_rxd", 32'(bus.uart_rxd), 32'd1);
        check("mid_rst_valid", 32'(bus.rx_valid), 32'd0);
        check("mid_rst_overflow", 32'(bus.rx_overflow), 32'd0);
        check("mid_rst_frame_err", 32'(bus.rx_frame_err), 32'd0);
        check("mid_rst_tx_ready", 32'(bus.tx_ready), 32'd0);
        tick(2);
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check("mid_rel_tx_ready", 32'(bus.tx_ready), 32'd1);
        tick(5);
        bus.rx_ready = 1'b1;
        popped.delete();
        rx_frame(8'h81, 1'b1);
        tick(20);
        check("x81_count", 32'(popped.size()), 32'd1);
        check("x81_value", 32'(popped[0]), 32'h81);
        check("x81_overflow", 32'(bus.rx_overflow), 32'd0);
        check("x81_frame_err", 32'(bus.rx_frame_err), 32'd0);

        bus.rx_ready = 1'b0;
        popped.delete();
        for (int i = 0; i < 8; i++) rx_frame(8'h10 + 8'(i), 1'b1);
        check("duplex_full_valid", 32'(bus.rx_valid), 32'd1);
        check("duplex_full_overflow", 32'(bus.rx_overflow), 32'd0);
        // The 0x0F stop bit is sampled 155 edges after its start bit is driven; pop on that same edge.
        fork
            rx_frame(8'h0F, 1'b1);
            begin
                tick(154);
                bus.rx_ready = 1'b1;
                tick(3);
                bus.rx_ready = 1'b0;
            end
            tx_send_check(8'hF0, "duplex_tx");
        join
        check("duplex_overflow", 32'(bus.rx_overflow), 32'd0);
        check("duplex_frame_err", 32'(bus.rx_frame_err), 32'd0);
        check("duplex_pop_count", 32'(popped.size()), 32'd3);
        tick(1);
        bus.rx_ready = 1'b1;
        tick(20);
        bus.rx_ready = 1'b0;
        check("duplex_total", 32'(popped.size()), 32'd9);
        for (int i = 0; i < 8; i++) check($sformatf("duplex_q%0d", i), 32'(popped[i]), 32'h10 + 32'(i));
        check("duplex_q8", 32'(popped[8]), 32'h0F);
        check("duplex_valid_end", 32'(bus.rx_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
